// File: rtl/text_pkg.sv
// Shared constants and state type for the character screen buffer.
// ASCII control/printable codes plus default screen geometry.
package text_pkg;

    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_BS = 8'h08;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_FF = 8'h0C;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    localparam int unsigned DEF_COLS = 80;
    localparam int unsigned DEF_ROWS = 30;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

endpackage

// File: rtl/text_ram.sv
// Simple dual-port (1W/1R) synchronous RAM, read-first, array left unreset
// so it maps onto block RAM.
module text_ram #(
    parameter int unsigned DEPTH  = 2400,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Both statements are non-blocking, so a same-cell read returns the old code.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/text_screen_buffer.sv
// Character screen memory: cursor-driven writes from a button latch, a 1-cycle
// read port for the VGA text renderer, clear sweep and cursor blink.
module text_screen_buffer
    import text_pkg::*;
#(
    parameter int unsigned COLS      = DEF_COLS,
    parameter int unsigned ROWS      = DEF_ROWS,
    parameter int unsigned BLINK_DIV = 50_000_000,
    localparam int unsigned COL_W    = $clog2(COLS),
    localparam int unsigned ROW_W    = $clog2(ROWS),
    localparam int unsigned ADDR_W   = $clog2(COLS * ROWS),
    localparam int unsigned BLINK_W  = $clog2(BLINK_DIV)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_pulse,
    input  logic [7:0]       wr_data,
    input  logic [ROW_W-1:0] rd_row,
    input  logic [COL_W-1:0] rd_col,
    output logic [7:0]       rd_data,
    output logic [ROW_W-1:0] cursor_row,
    output logic [COL_W-1:0] cursor_col,
    output logic             cursor_on,
    output logic             busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               cursor_on_q, cursor_on_d;
    logic               rd_vld_q;
    logic               rd_oor_q, rd_oor_d;

    logic               accept;
    logic               we;
    logic [ADDR_W-1:0]  waddr;
    logic [7:0]         wdata;
    logic               re;
    logic [ADDR_W-1:0]  raddr;
    logic [7:0]         ram_rdata;

    logic               col_last, row_last, at_origin, is_print;
    logic [ROW_W-1:0]   nl_row, adv_row, bs_row;
    logic [COL_W-1:0]   adv_col, bs_col;
    logic [ADDR_W-1:0]  cur_addr, bs_addr;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                    input logic [COL_W-1:0] c);
        return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    always_comb begin
        col_last  = (col_q == LAST_COL);
        row_last  = (row_q == LAST_ROW);
        at_origin = (row_q == '0) && (col_q == '0);
        is_print  = (wr_data >= PRINT_LO) && (wr_data <= PRINT_HI);
        nl_row    = row_last ? '0 : row_q + 1'b1;
        adv_col   = col_last ? '0 : col_q + 1'b1;
        adv_row   = col_last ? nl_row : row_q;
        bs_col    = (col_q == '0) ? LAST_COL : col_q - 1'b1;
        bs_row    = (col_q == '0) ? row_q - 1'b1 : row_q;
        cur_addr  = cell_addr(row_q, col_q);
        bs_addr   = cell_addr(bs_row, bs_col);
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        row_d      = row_q;
        col_d      = col_q;
        accept     = 1'b0;
        we         = 1'b0;
        waddr      = cur_addr;
        wdata      = wr_data;
        case (state_q)
            CLEAR: begin
                we         = 1'b1;
                waddr      = clr_addr_q;
                wdata      = ASCII_SP;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = IDLE;
                    clr_addr_d = '0;
                end
            end
            IDLE: begin
                if (wr_pulse) begin
                    if (is_print) begin
                        accept = 1'b1;
                        we     = 1'b1;
                        row_d  = adv_row;
                        col_d  = adv_col;
                    end else begin
                        case (wr_data)
                            ASCII_LF, ASCII_CR: begin
                                accept = 1'b1;
                                row_d  = nl_row;
                                col_d  = '0;
                            end
                            ASCII_BS: begin
                                if (!at_origin) begin
                                    accept = 1'b1;
                                    we     = 1'b1;
                                    waddr  = bs_addr;
                                    wdata  = ASCII_SP;
                                    row_d  = bs_row;
                                    col_d  = bs_col;
                                end
                            end
                            ASCII_FF: begin
                                accept     = 1'b1;
                                row_d      = '0;
                                col_d      = '0;
                                clr_addr_d = '0;
                                state_d    = CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Any accepted command restarts the blink phase with the cursor visible.
    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        cursor_on_d = cursor_on_q;
        if (accept) begin
            blink_cnt_d = '0;
            cursor_on_d = 1'b1;
        end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            cursor_on_d = ~cursor_on_q;
        end
    end

    always_comb begin
        rd_oor_d = (32'(rd_row) >= ROWS) || (32'(rd_col) >= COLS);
        re       = ~rd_oor_d;
        raddr    = cell_addr(rd_row, rd_col);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= CLEAR;
            clr_addr_q  <= '0;
            row_q       <= '0;
            col_q       <= '0;
            blink_cnt_q <= '0;
            cursor_on_q <= 1'b1;
            rd_vld_q    <= 1'b0;
            rd_oor_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            row_q       <= row_d;
            col_q       <= col_d;
            blink_cnt_q <= blink_cnt_d;
            cursor_on_q <= cursor_on_d;
            rd_vld_q    <= 1'b1;
            rd_oor_q    <= rd_oor_d;
        end
    end

    text_ram #(
        .DEPTH  (COLS * ROWS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .re_i    (re),
        .raddr_i (raddr),
        .rdata_o (ram_rdata)
    );

    // The RAM output register has no reset, so mask it until the first read lands.
    always_comb begin
        if (!rd_vld_q) begin
            rd_data = 8'h00;
        end else if (rd_oor_q) begin
            rd_data = ASCII_SP;
        end else begin
            rd_data = ram_rdata;
        end
    end

    assign cursor_row = row_q;
    assign cursor_col = col_q;
    assign cursor_on  = cursor_on_q;
    assign busy       = (state_q == CLEAR);

endmodule

// File: tb/tb_text_screen_buffer.sv
// Bench for text_screen_buffer on a 4x2 screen: directed tables, corner sequences
// and random commands, all checked against a cell-array/linear-cursor model.
module tb_text_screen_buffer;

    localparam int COLS  = 4;
    localparam int ROWS  = 2;
    localparam int CELLS = COLS * ROWS;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_pulse;
    logic [7:0] wr_data;
    logic [0:0] rd_row;
    logic [1:0] rd_col;
    logic [7:0] rd_data;
    logic [0:0] cursor_row;
    logic [1:0] cursor_col;
    logic       cursor_on;
    logic       busy;

    always #5 clk = ~clk;

    text_screen_buffer #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .BLINK_DIV (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_pulse   (wr_pulse),
        .wr_data    (wr_data),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_data    (rd_data),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .cursor_on  (cursor_on),
        .busy       (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: cell array, linear cursor index, sweep cycles left, cycles since blink restart.
    logic [7:0] m_mem [CELLS];
    bit         m_known [CELLS];
    int         m_pos;
    int         m_clr;
    int         m_t;
    logic [7:0] m_rd;
    bit         m_rd_known;

    typedef struct {
        logic [7:0] data;
        int         exp_row;
        int         exp_col;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos      = 0;
        m_clr      = CELLS;
        m_t        = 0;
        m_rd       = 8'h00;
        m_rd_known = 1'b1;
    endtask

    task automatic model_step(input bit w, input logic [7:0] d, input int r, input int c);
        bit restart = 1'b0;
        int idx;
        if (r >= ROWS || c >= COLS) begin
            m_rd       = 8'h20;
            m_rd_known = 1'b1;
        end else begin
            idx        = r * COLS + c;
            m_rd       = m_mem[idx];
            m_rd_known = m_known[idx];
        end
        if (m_clr > 0) begin
            m_mem[CELLS - m_clr]   = 8'h20;
            m_known[CELLS - m_clr] = 1'b1;
            m_clr--;
        end else if (w) begin
            if (d >= 8'h20 && d <= 8'h7E) begin
                m_mem[m_pos]   = d;
                m_known[m_pos] = 1'b1;
                m_pos          = (m_pos + 1) % CELLS;
                restart        = 1'b1;
            end else if (d == 8'h0A || d == 8'h0D) begin
                m_pos   = ((m_pos / COLS + 1) % ROWS) * COLS;
                restart = 1'b1;
            end else if (d == 8'h08) begin
                if (m_pos > 0) begin
                    m_pos--;
                    m_mem[m_pos]   = 8'h20;
                    m_known[m_pos] = 1'b1;
                    restart        = 1'b1;
                end
            end else if (d == 8'h0C) begin
                m_pos   = 0;
                m_clr   = CELLS;
                restart = 1'b1;
            end
        end
        m_t = restart ? 0 : m_t + 1;
    endtask

    task automatic check_outputs();
        check("busy", int'(busy), int'(m_clr > 0));
        check("cursor_row", int'(cursor_row), m_pos / COLS);
        check("cursor_col", int'(cursor_col), m_pos % COLS);
        check("cursor_on", int'(cursor_on), int'(((m_t / 8) % 2) == 0));
        if (m_rd_known) begin
            check("rd_data", int'(rd_data), int'(m_rd));
        end
    endtask

    task automatic tick(input bit w, input logic [7:0] d, input int r, input int c);
        wr_pulse = w;
        wr_data  = d;
        rd_row   = 1'(r);
        rd_col   = 2'(c);
        @(posedge clk);
        model_step(w, d, r, c);
        #1;
        wr_pulse = 1'b0;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        #2;
        reset = 1'b0;
    endtask

    task automatic wait_clear(input string name, input bit spam);
        int n = 0;
        while (busy && n < 20) begin
            tick(spam, 8'h5A, n / COLS % ROWS, n % COLS);
            n++;
        end
        check(name, n, CELLS);
    endtask

    task automatic read_cell(input string name, input int idx, input int exp);
        tick(1'b0, 8'h00, idx / COLS, idx % COLS);
        check(name, int'(rd_data), exp);
    endtask

    task automatic check_cursor(input string name, input int r, input int c);
        check({name, "_row"}, int'(cursor_row), r);
        check({name, "_col"}, int'(cursor_col), c);
    endtask

    initial begin
        logic [7:0] exp_all [CELLS];
        logic [7:0] code;
        int         pick;

        for (int i = 0; i < CELLS; i++) begin
            m_mem[i]   = 8'h00;
            m_known[i] = 1'b0;
        end
        reset    = 1'b1;
        wr_pulse = 1'b0;
        wr_data  = 8'h00;
        rd_row   = '0;
        rd_col   = '0;
        model_reset();
        #1;
        check_outputs();
        check("reset_rd_data", int'(rd_data), 0);
        #12;
        reset = 1'b0;

        wait_clear("init_busy_cycles", 1'b0);
        for (int i = 0; i < CELLS; i++) read_cell("init_cell", i, 8'h20);
        check_cursor("init_cursor", 0, 0);

        tbl[0]  = '{8'h41, 0, 1};
        tbl[1]  = '{8'h42, 0, 2};
        tbl[2]  = '{8'h43, 0, 3};
        tbl[3]  = '{8'h44, 1, 0};
        tbl[4]  = '{8'h45, 1, 1};
        tbl[5]  = '{8'h61, 1, 2};
        tbl[6]  = '{8'h62, 1, 3};
        tbl[7]  = '{8'h63, 0, 0};
        tbl[8]  = '{8'h64, 0, 1};
        tbl[9]  = '{8'h65, 0, 2};
        tbl[10] = '{8'h66, 0, 3};
        tbl[11] = '{8'h67, 1, 0};
        tbl[12] = '{8'h68, 1, 1};

        for (int i = 0; i < 13; i++) begin
            tick(1'b1, tbl[i].data, 0, 0);
            check_cursor("tbl_cursor", tbl[i].exp_row, tbl[i].exp_col);
            if (i == 4) begin
                for (int k = 0; k < 5; k++) read_cell("abcde_cell", k, 8'h41 + k);
            end
        end
        exp_all = '{8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h61, 8'h62, 8'h63};
        for (int i = 0; i < CELLS; i++) read_cell("wrap_cell", i, int'(exp_all[i]));

        // Backspace from (1,1) to (1,0), then across the row boundary to (0,3).
        tick(1'b1, 8'h08, 0, 0);
        check_cursor("bs1", 1, 0);
        tick(1'b1, 8'h08, 1, 0);
        check_cursor("bs2", 0, 3);
        read_cell("bs_cell_10", 4, 8'h20);
        read_cell("bs_cell_03", 3, 8'h20);

        // Form feed with writes hammered during the sweep.
        tick(1'b1, 8'h0C, 0, 0);
        check("ff_busy", int'(busy), 1);
        wait_clear("ff_busy_cycles", 1'b1);
        for (int i = 0; i < CELLS; i++) read_cell("ff_cell", i, 8'h20);
        check_cursor("ff_cursor", 0, 0);

        tick(1'b1, 8'h08, 0, 0);
        check_cursor("bs_origin", 0, 0);
        tick(1'b1, 8'h51, 0, 0);
        tick(1'b1, 8'h07, 0, 0);
        check_cursor("bell_ignored", 0, 1);
        read_cell("bell_cell0", 0, 8'h51);
        read_cell("bell_cell1", 1, 8'h20);

        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 0, 0);
        tick(1'b1, 8'h78, 0, 0);
        check("blink_forced_on", int'(cursor_on), 1);
        for (int i = 1; i <= 8; i++) begin
            tick(1'b0, 8'h00, 0, 0);
            check("blink_phase", int'(cursor_on), int'(i < 8));
        end

        // Reset in the middle of a form-feed sweep.
        tick(1'b1, 8'h0C, 0, 0);
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1, i);
        do_reset();
        check("midreset_busy", int'(busy), 1);
        wait_clear("midreset_busy_cycles", 1'b0);
        check_cursor("midreset_cursor", 0, 0);

        for (int n = 0; n < 600; n++) begin
            pick = $urandom_range(0, 99);
            if (pick < 60) code = 8'($urandom_range(8'h20, 8'h7E));
            else if (pick < 66) code = 8'h0A;
            else if (pick < 70) code = 8'h0D;
            else if (pick < 84) code = 8'h08;
            else if (pick < 86) code = 8'h0C;
            else if (pick < 93) code = 8'($urandom_range(8'h7F, 8'hFF));
            else code = 8'h07;
            tick(($urandom_range(0, 9) < 4), code, $urandom_range(0, ROWS - 1),
                 $urandom_range(0, COLS - 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
